// File: rtl/dl_debounce.sv
`default_nettype none
// ============================================================================
// Module  : dl_debounce
// Brief   : Synchronizes a raw level and accepts a change only after it has
//           persisted for DEBOUNCE_CYC consecutive sampled cycles.
// Revision: 1.0 - initial release
// ============================================================================
module dl_debounce #(
    parameter int   SYNC_STAGES  = 2,
    parameter int   DEBOUNCE_CYC = 8,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    typedef enum logic [0:0] {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_d_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_q;
    logic                   r_rise;
    logic                   r_fall;

    // Synchronizer keeps shifting even while the accept logic is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign w_d_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_q     <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!en) begin
                r_state <= STABLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    STABLE: begin
                        if (w_d_sync != r_q) begin
                            r_state <= COUNTING;
                            r_cnt   <= c_CNT_ONE;
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                    COUNTING: begin
                        if (w_d_sync == r_q) begin
                            // Level fell back before it was accepted: glitch
                            r_state <= STABLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_q     <= w_d_sync;
                            r_rise  <= w_d_sync;
                            r_fall  <= ~w_d_sync;
                            r_state <= STABLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (r_state == COUNTING);

endmodule
`default_nettype wire

// File: tb/tb_dl_debounce.sv
`default_nettype none
// Testbench for dl_debounce: random and directed stimulus against a
// run-length reference model of the accept rule.
module tb_dl_debounce;

    localparam int   SYNC = 2;
    localparam int   DC   = 4;
    localparam logic RV   = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    logic d;
    logic en;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: delay line for the synchronizer, run length of
    // consecutive disagreeing samples for the accept rule.
    logic mpipe[$];
    logic mq;
    logic mrise;
    logic mfall;
    int   mrun;

    dl_debounce #(
        .SYNC_STAGES (SYNC),
        .DEBOUNCE_CYC(DC),
        .RESET_VAL   (RV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d),
        .en   (en),
        .q    (q),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mpipe.delete();
        for (int i = 0; i < SYNC; i++) mpipe.push_back(RV);
        mq    = RV;
        mrise = 1'b0;
        mfall = 1'b0;
        mrun  = 0;
    endtask

    task automatic model_edge();
        logic ds;
        ds = mpipe.pop_front();
        mpipe.push_back(d);
        mrise = 1'b0;
        mfall = 1'b0;
        if (en && (ds !== mq)) mrun++;
        else                   mrun = 0;
        if (mrun == DC) begin
            mq    = ds;
            mrise = ds;
            mfall = !ds;
            mrun  = 0;
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic settle(input logic v);
        d = v;
        for (int i = 0; i < SYNC + DC + 3; i++) tick();
    endtask

    task automatic test_reset();
        d = 1'b0; en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        d = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({q, rise, fall, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_immediate: got %b expected 0000", {q, rise, fall, busy});
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_checks++;
            if ({q, rise, fall, busy} !== {mq, mrise, mfall, (mrun != 0)}) begin
                n_fail++;
                $display("FAIL reset_model e=%0d: got %b expected %b", e,
                         {q, rise, fall, busy}, {mq, mrise, mfall, (mrun != 0)});
            end
            n_checks++;
            if ({q, rise} !== ((e < 6) ? 2'b00 : (e == 6) ? 2'b11 : 2'b10)) begin
                n_fail++;
                $display("FAIL reset_release_latency e=%0d: got q,rise=%b%b", e, q, rise);
            end
        end
    endtask

    task automatic test_glitch();
        int busy_cycles;
        logic saw_rise;
        settle(1'b0);
        busy_cycles = 0;
        saw_rise    = 1'b0;
        d = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 3) d = 1'b0;
            if (busy) busy_cycles++;
            if (rise) saw_rise = 1'b1;
            n_checks++;
            if ({q, rise, fall, busy} !== {mq, mrise, mfall, (mrun != 0)}) begin
                n_fail++;
                $display("FAIL glitch_model e=%0d: got %b expected %b", e,
                         {q, rise, fall, busy}, {mq, mrise, mfall, (mrun != 0)});
            end
        end
        n_checks++;
        if (busy_cycles != 3 || saw_rise || q !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject: busy_cycles=%0d rise_seen=%b q=%b expected 3 0 0",
                     busy_cycles, saw_rise, q);
        end
        settle(1'b0);
        d = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 4) d = 1'b0;
            n_checks++;
            if ({q, rise} !== ((e == 6) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL glitch_accept4 e=%0d: got q,rise=%b%b", e, q, rise);
            end
        end
    endtask

    task automatic test_fall();
        settle(1'b1);
        d = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_checks++;
            if ({q, fall, rise} !== ((e < 6) ? 3'b100 : (e == 6) ? 3'b010 : 3'b000)) begin
                n_fail++;
                $display("FAIL fall_latency e=%0d: got q,fall,rise=%b%b%b", e, q, fall, rise);
            end
        end
    endtask

    task automatic test_enable_abort();
        settle(1'b0);
        d = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            en = (e == 4) ? 1'b0 : 1'b1;
            tick();
            n_checks++;
            if ({q, rise, fall, busy} !== {mq, mrise, mfall, (mrun != 0)}) begin
                n_fail++;
                $display("FAIL enable_model e=%0d: got %b expected %b", e,
                         {q, rise, fall, busy}, {mq, mrise, mfall, (mrun != 0)});
            end
            if (e == 4) begin
                n_checks++;
                if (busy !== 1'b0 || dut.r_cnt !== '0 || q !== 1'b0) begin
                    n_fail++;
                    $display("FAIL enable_abort: busy=%b cnt=%0d q=%b expected 0 0 0",
                             busy, dut.r_cnt, q);
                end
            end
            if (e == 7 || e == 8) begin
                n_checks++;
                if (q !== (e == 8)) begin
                    n_fail++;
                    $display("FAIL enable_restart e=%0d: got q=%b expected %b", e, q, (e == 8));
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_midcount();
        settle(1'b0);
        d = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midcount_busy_before: got %b expected 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({busy, rise, q} !== 3'b000) begin
            n_fail++;
            $display("FAIL midcount_reset_immediate: got busy,rise,q=%b expected 000", {busy, rise, q});
        end
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_checks++;
            if ({q, rise} !== ((e == 6) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL midcount_release e=%0d: got q,rise=%b%b", e, q, rise);
            end
        end
    endtask

    task automatic test_chatter();
        int bad;
        settle(1'b0);
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            d = ((c / 3) % 2) == 1;
            tick();
            if ({q, rise, fall} !== 3'b000) bad++;
        end
        n_checks++;
        if (bad != 0 || mq !== 1'b0) begin
            n_fail++;
            $display("FAIL chatter: %0d cycles with q/rise/fall set, model q=%b, expected none", bad, mq);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                d    = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 7);
            end
            hold--;
            en = ($urandom_range(0, 15) != 0);
            tick();
            n_checks++;
            if ({q, rise, fall, busy} !== {mq, mrise, mfall, (mrun != 0)}) begin
                n_fail++;
                $display("FAIL random_model c=%0d: got %b expected %b", c,
                         {q, rise, fall, busy}, {mq, mrise, mfall, (mrun != 0)});
            end
            n_checks++;
            if (rise && fall) begin
                n_fail++;
                $display("FAIL random_exclusive c=%0d: rise and fall both 1", c);
            end
        end
        en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 1'b0;
        en    = 1'b1;
        model_reset();
        test_reset();
        test_glitch();
        test_fall();
        test_enable_abort();
        test_reset_midcount();
        test_chatter();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dl_debounce.md
DL_DEBOUNCE -- requirements
Module: dl_debounce

Interface
- REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of input synchronizer flops; legal values are 2 and above.
- REQ-002 SHALL have parameter DEBOUNCE_CYC, default 8: number of consecutive sampled cycles a new level must persist before it is accepted; legal values are 2 and above.
- REQ-003 SHALL have parameter RESET_VAL, default 1'b0: reset value of the synchronizer chain and of q.
- REQ-004 `clk` input 1: single clock; all state updates on the rising edge.
- REQ-005 `rst_n` input 1: reset, asynchronous, active-low.
- REQ-006 `d` input 1: raw, possibly asynchronous and bouncing input level.
- REQ-007 `en` input 1: debounce enable; when low, the accept logic is held idle.
- REQ-008 `q` output 1: debounced, registered level.
- REQ-009 `rise` output 1: registered one-cycle pulse when q goes 0 to 1.
- REQ-010 `fall` output 1: registered one-cycle pulse when q goes 1 to 0.
- REQ-011 `busy` output 1: high while a candidate level change is being counted.

Function
- REQ-012 SHALL pass d through a chain of SYNC_STAGES D flip-flops; the last stage is d_sync, and only d_sync feeds the control logic.
- REQ-013 The synchronizer SHALL shift every cycle regardless of en.
- REQ-014 SHALL implement a two-state FSM, STABLE and COUNTING, plus a counter of width $clog2(DEBOUNCE_CYC).
- REQ-015 STABLE, en=1, d_sync!=q: go to COUNTING, cnt<=1.
- REQ-016 STABLE, d_sync==q: stay in STABLE, cnt<=0.
- REQ-017 COUNTING, en=1, d_sync==q: go to STABLE, cnt<=0, q unchanged, no pulse (glitch rejected).
- REQ-018 COUNTING, en=1, d_sync!=q, cnt<DEBOUNCE_CYC-1: cnt<=cnt+1.
- REQ-019 COUNTING, en=1, d_sync!=q, cnt==DEBOUNCE_CYC-1: q<=d_sync, go to STABLE, cnt<=0.
- REQ-020 With REQ-015 to REQ-019, q changes on the DEBOUNCE_CYC-th consecutive edge at which d_sync!=q.
- REQ-021 Latency from a clean step on d (set up before edge 1) to q changing SHALL be exactly SYNC_STAGES+DEBOUNCE_CYC edges.
- REQ-022 rise/fall SHALL be asserted at the same edge that q changes, for exactly one cycle; they are never high together, and both are 0 on every other cycle.
- REQ-023 busy SHALL equal (state==COUNTING); it is derived from registered state only and is glitch-free.
- REQ-024 en=0 in any state: next state STABLE, cnt<=0, q held, rise=fall=0. A count aborted this way restarts from 1 after en returns.
- REQ-025 The counter SHALL never exceed DEBOUNCE_CYC-1 and SHALL never wrap.
- REQ-026 An input toggling continuously with period shorter than 2*DEBOUNCE_CYC SHALL never change q.

Reset
- REQ-027 rst_n=0 SHALL immediately, without waiting for clk, set: synchronizer stages=RESET_VAL, q=RESET_VAL, state=STABLE, cnt=0, rise=fall=busy=0.
- REQ-028 Reset asserted mid-count SHALL discard the count with no pulse.
- REQ-029 After rst_n rises, normal operation SHALL start at the first rising clk edge.

Verification (SYNC_STAGES=2, DEBOUNCE_CYC=4, RESET_VAL=0, en=1 unless stated)
- REQ-030 Reset: hold d=1 and assert rst_n=0 between edges -> q, rise, fall and busy are 0 immediately. Release rst_n with d=1 held -> q=1 and rise=1 at edge 6 after release, rise=0 at edge 7.
- REQ-031 Glitch: q=0, d=1 held for 3 edges then d=0 -> busy high for 3 cycles, q stays 0, rise never asserts. Repeat with d=1 held for exactly 4 edges -> q=1 at edge 6.
- REQ-032 Fall: q=1 settled, d=0 held -> fall=1 and q=0 at edge 6; fall=0 at edge 7.
- REQ-033 Enable abort: d=1 held, drop en for 1 cycle at edge 4 -> busy=0, cnt=0, q stays 0. With en high again and d=1 still held, q=1 exactly 4 edges later.
- REQ-034 Reset mid-count: d=1 held, rst_n=0 pulsed after edge 4 -> busy drops immediately, no rise, and q=1 only at edge 6 counted from reset release.
- REQ-035 Chatter: toggle d every 3 cycles for 60 cycles -> q constant at 0, rise=fall=0 throughout.
